// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a single shared register, with an optional
// lock mode enabled by defining REG_WRITE_ARBITER_LOCK_EN.
//
// Handshake: a requester holds req[i] and its wdata lane stable until it sees gnt[i].
// The grant, reg_load and reg_d appear one cycle after req is sampled.
// reg_load is high exactly when one gnt bit is high.
// There is no ready back-pressure: each grant is a single-cycle load.
module reg_write_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         lock,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic               reg_load,
  output logic [WIDTH-1:0]   reg_d,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_d;
  logic             load_d;
  logic [WIDTH-1:0] reg_d_d;
  logic [1:0]       owner_d;
  logic [2:0]       lock_cnt_q, lock_cnt_d;
  logic             rr_found;
  logic [1:0]       rr_idx;
  logic             lock_win;
  logic             owner_held;

`ifdef REG_WRITE_ARBITER_LOCK_EN
  assign lock_win   = lock[rr_idx];
  assign owner_held = req[owner] & lock[owner];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_win    = 1'b0;
  assign owner_held  = 1'b0;
`endif

  // Search starts one past the current owner; k=4 wraps back to the owner itself.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && req[owner + 2'(k)]) begin
        rr_found = 1'b1;
        rr_idx   = owner + 2'(k);
      end
    end
  end

  always_comb begin
    logic arbitrate;
    state_d    = state_q;
    gnt_d      = 4'b0000;
    load_d     = 1'b0;
    reg_d_d    = reg_d;
    owner_d    = owner;
    lock_cnt_d = 3'd0;
    arbitrate  = 1'b0;

    case (state_q)
      LOCKED: begin
        if (!owner_held) begin
          state_d = IDLE;
        end else if (lock_cnt_q != 3'd7) begin
          gnt_d      = 4'b0001 << owner;
          load_d     = 1'b1;
          reg_d_d    = wdata[int'(owner)*WIDTH +: WIDTH];
          lock_cnt_d = lock_cnt_q + 3'd1;
        end else begin
          // Eighth locked grant already issued: forced release.
          arbitrate = 1'b1;
        end
      end
      default: arbitrate = 1'b1;
    endcase

    if (arbitrate) begin
      if (rr_found) begin
        gnt_d   = 4'b0001 << rr_idx;
        load_d  = 1'b1;
        reg_d_d = wdata[int'(rr_idx)*WIDTH +: WIDTH];
        owner_d = rr_idx;
        state_d = lock_win ? LOCKED : GRANT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt        <= 4'b0000;
      reg_load   <= 1'b0;
      reg_d      <= '0;
      owner      <= 2'd3;
      lock_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      gnt        <= gnt_d;
      reg_load   <= load_d;
      reg_d      <= reg_d_d;
      owner      <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign busy      = (state_q == LOCKED);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus random
// traffic compared against a cycle-level reference model.
module tb_reg_write_arbiter;
  localparam int WIDTH = 4;

`ifdef REG_WRITE_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req;
  logic [3:0]         lock;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         gnt;
  logic               reg_load;
  logic [WIDTH-1:0]   reg_d;
  logic [1:0]         owner;
  logic               busy;
  logic [1:0]         state_dbg;

  int passed = 0;
  int total  = 0;

  // Reference model: current winner, lock episode flag and grants issued in it.
  logic [3:0]       m_gnt;
  logic             m_load;
  logic [WIDTH-1:0] m_d;
  int               m_owner;
  bit               m_locked;
  int               m_run;

  logic [WIDTH-1:0] exp_q[$];

  logic [WIDTH+7:0] obs, expv;
  assign obs  = {gnt, reg_load, reg_d, owner, busy};
  assign expv = {m_gnt, m_load, m_d, m_owner[1:0], m_locked};

  reg_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .reg_load(reg_load), .reg_d(reg_d), .owner(owner),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_grant(input int w);
    m_gnt  = 4'b0001 << w;
    m_load = 1'b1;
    m_d    = wdata[w*WIDTH +: WIDTH];
  endtask

  // Applies the arbitration rules to the inputs present at this clock edge.
  task automatic model_edge();
    int w;
    if (rst) begin
      m_gnt = 0; m_load = 0; m_d = 0; m_owner = 3; m_locked = 0; m_run = 0;
      return;
    end
    m_gnt  = 0;
    m_load = 0;
    if (m_locked && !(req[m_owner] && lock[m_owner])) begin
      m_locked = 0;
      m_run    = 0;
    end else if (m_locked && m_run < 8) begin
      model_grant(m_owner);
      m_run++;
    end else begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && req[(m_owner + k) % 4]) w = (m_owner + k) % 4;
      if (w < 0) begin
        m_locked = 0;
        m_run    = 0;
      end else begin
        model_grant(w);
        m_owner  = w;
        m_locked = LOCK_EN && lock[w];
        m_run    = m_locked ? 1 : 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] q, input logic [3:0] l,
                       input logic [4*WIDTH-1:0] d);
    rst = r; req = q; lock = l; wdata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'b1111, 4'b1111, 16'hFFFF);
    total++;
    if (obs !== {4'b0000, 1'b0, 4'h0, 2'd3, 1'b0})
      $display("FAIL reset_outputs: got %h want %h", obs, {4'b0000, 1'b0, 4'h0, 2'd3, 1'b0});
    else passed++;
    total++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);
    else passed++;
  endtask

  task automatic test_single();
    cycle(1'b0, 4'b0001, 4'b0000, 16'h0005);
    total++;
    if (obs !== {4'b0001, 1'b1, 4'h5, 2'd0, 1'b0})
      $display("FAIL single_grant: got %h want %h", obs, {4'b0001, 1'b1, 4'h5, 2'd0, 1'b0});
    else passed++;
    cycle(1'b0, 4'b0000, 4'b0000, 16'h0000);
    total++;
    if (obs !== expv) $display("FAIL single_release: got %h want %h", obs, expv);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [WIDTH-1:0] got;
    cycle(1'b1, 4'b0000, 4'b0000, 16'h0000);
    exp_q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b1111, 4'b0000, 16'h4321);
      total++;
      if (gnt !== seq[i]) $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt, seq[i]);
      else passed++;
      if (reg_load && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        total++;
        if (reg_d !== got) $display("FAIL rr_data_%0d: got %h want %h", i, reg_d, got);
        else passed++;
      end
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d left want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_idle_hold();
    cycle(1'b0, 4'b0100, 4'b0000, 16'h0C00);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b0000, 4'b0000, 16'($urandom));
      total++;
      if (obs !== {4'b0000, 1'b0, 4'hC, 2'd2, 1'b0})
        $display("FAIL idle_hold_%0d: got %h want %h", i, obs, {4'b0000, 1'b0, 4'hC, 2'd2, 1'b0});
      else passed++;
    end
  endtask

  task automatic test_lock();
    logic [3:0] want_gnt;
    logic       want_busy;
    cycle(1'b1, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 4'b0011, LOCK_EN ? 4'b0001 : 4'b1111, 16'($urandom));
      if (LOCK_EN) begin
        want_gnt  = (i <= 8) ? 4'b0001 : 4'b0010;
        want_busy = (i <= 8);
      end else begin
        want_gnt  = (i % 2 == 1) ? 4'b0001 : 4'b0010;
        want_busy = 1'b0;
      end
      if (i <= 9) begin
        total++;
        if ({gnt, busy} !== {want_gnt, want_busy})
          $display("FAIL lock_seq_%0d: got %b/%b want %b/%b", i, gnt, busy, want_gnt, want_busy);
        else passed++;
      end
      total++;
      if (obs !== expv) $display("FAIL lock_model_%0d: got %h want %h", i, obs, expv);
      else passed++;
    end
  endtask

  task automatic test_lock_drop();
    logic [3:0] q [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] l [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    cycle(1'b1, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, q[i], l[i], 16'($urandom));
      total++;
      if (obs !== expv) $display("FAIL lock_drop_%0d: got %h want %h", i, obs, expv);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_lock();
    cycle(1'b1, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0011, 4'b1111, 16'h7777);
    cycle(1'b1, 4'b0011, 4'b1111, 16'h7777);
    total++;
    if (obs !== {4'b0000, 1'b0, 4'h0, 2'd3, 1'b0})
      $display("FAIL midlock_reset: got %h want %h", obs, {4'b0000, 1'b0, 4'h0, 2'd3, 1'b0});
    else passed++;
    cycle(1'b0, 4'b1000, 4'b0000, 16'h9000);
    total++;
    if (obs !== {4'b1000, 1'b1, 4'h9, 2'd3, 1'b0})
      $display("FAIL midlock_after: got %h want %h", obs, {4'b1000, 1'b1, 4'h9, 2'd3, 1'b0});
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0] q = 4'b0000;
    logic [3:0] l = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        q = 4'($urandom);
        l = 4'($urandom) | 4'($urandom);
      end
      cycle($urandom_range(0, 49) == 0, q, l, 16'($urandom));
      total++;
      if (obs !== expv) $display("FAIL random_%0d: got %h want %h", i, obs, expv);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; lock = 4'b0000; wdata = '0;
    m_gnt = 0; m_load = 0; m_d = 0; m_owner = 3; m_locked = 0; m_run = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_idle_hold();
    test_lock();
    test_lock_drop();
    test_reset_mid_lock();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
